// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between a priority pipeline port and a DMA port.
// Defining ALIGN_CHECK_EN adds p0_err/p1_err and suppresses misaligned/out-of-range accesses.
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
`ifdef ALIGN_CHECK_EN
    output logic              p0_err,
    output logic              p1_err,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {NONE, OWN0, OWN1} owner_t;
    owner_t        rd_owner;
    logic [CW-1:0] starve_cnt;
    logic          force1, g_any, g_we, bad, rd_bad;
    logic [31:0]   g_addr, g_wdata;
    logic          unused_addr;
    always_comb begin
        force1    = starve_cnt == CW'(STARVE_MAX);
        p1_gnt    = !rst && p1_req && (!p0_req || force1);
        p0_gnt    = !rst && p0_req && !p1_gnt;
        g_any     = p0_gnt || p1_gnt;
        g_we      = p1_gnt ? p1_we : p0_we;
        g_addr    = p1_gnt ? p1_addr : p0_addr;
        g_wdata   = p1_gnt ? p1_wdata : p0_wdata;
`ifdef ALIGN_CHECK_EN
        bad       = (|g_addr[1:0]) || (|g_addr[31:ADDR_W+2]);
`else
        bad       = 1'b0;
`endif
        mem_en    = g_any && !bad;
        mem_we    = mem_en && g_we;
        mem_addr  = mem_en ? g_addr[ADDR_W+1:2] : '0;
        mem_wdata = mem_en ? g_wdata : '0;
    end
    assign unused_addr = ^{g_addr[31:ADDR_W+2], g_addr[1:0]};
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            rd_owner   <= NONE;
            rd_bad     <= 1'b0;
        end else begin
            starve_cnt <= (p1_req && !p1_gnt) ? (force1 ? starve_cnt : starve_cnt + 1'b1) : '0;
            rd_owner   <= (g_any && !g_we) ? (p1_gnt ? OWN1 : OWN0) : NONE;
            rd_bad     <= bad;
        end
    end
`ifdef ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_err <= 1'b0;
            p1_err <= 1'b0;
        end else begin
            p0_err <= p0_gnt && bad;
            p1_err <= p1_gnt && bad;
        end
    end
`endif
    // rvalid is masked during reset so a pending read never surfaces while rst is high
    assign p0_rvalid = !rst && rd_owner == OWN0;
    assign p1_rvalid = !rst && rd_owner == OWN1;
    assign p0_rdata  = (p0_rvalid && !rd_bad) ? mem_rdata : '0;
    assign p1_rdata  = (p1_rvalid && !rd_bad) ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a per-cycle behavioural model of the arbiter and memory.
module tb_dmem_arbiter;
    localparam int ADDR_W = 10;
    localparam int SM     = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid, p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
    logic        mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata = 32'h0;
    logic [31:0] bmem [1024];
    logic [31:0] model_mem [1024];
    int passed = 0, total = 0;
    int m_starve = 0, m_pend = 0;
    logic [31:0] m_pdata = 32'h0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en && mem_we) bmem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= bmem[mem_addr];
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: priority with a denied-cycle count, shadow memory, one pending read response.
    always @(negedge clk) begin
        bit g0, g1, we;
        logic [31:0] a, d;
        int w;
        if (rst) begin
            chk("rst_p0_gnt", p0_gnt, 0);
            chk("rst_p1_gnt", p1_gnt, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_p0_rvalid", p0_rvalid, 0);
            chk("rst_p1_rvalid", p1_rvalid, 0);
            chk("rst_p0_rdata", p0_rdata, 0);
            chk("rst_p1_rdata", p1_rdata, 0);
            m_pend = 0;
            m_starve = 0;
        end else begin
            g1 = p1_req && (!p0_req || m_starve >= SM);
            g0 = p0_req && !g1;
            a  = g1 ? p1_addr : p0_addr;
            d  = g1 ? p1_wdata : p0_wdata;
            we = g1 ? p1_we : p0_we;
            w  = int'((a >> 2) % 1024);
            chk("m_p0_gnt", p0_gnt, g0);
            chk("m_p1_gnt", p1_gnt, g1);
            chk("m_mem_en", mem_en, g0 || g1);
            chk("m_mem_we", mem_we, (g0 || g1) && we);
            chk("m_mem_addr", mem_addr, (g0 || g1) ? 32'(w) : 0);
            chk("m_mem_wdata", mem_wdata, (g0 || g1) ? d : 0);
            chk("m_p0_rvalid", p0_rvalid, m_pend == 1);
            chk("m_p1_rvalid", p1_rvalid, m_pend == 2);
            chk("m_p0_rdata", p0_rdata, m_pend == 1 ? m_pdata : 0);
            chk("m_p1_rdata", p1_rdata, m_pend == 2 ? m_pdata : 0);
            m_pend = ((g0 || g1) && !we) ? (g1 ? 2 : 1) : 0;
            if ((g0 || g1) && !we) m_pdata = model_mem[w];
            if ((g0 || g1) && we) model_mem[w] = d;
            m_starve = (p1_req && !g1) ? (m_starve < SM ? m_starve + 1 : SM) : 0;
        end
    end

    task automatic drive(bit r0, bit w0, logic [31:0] a0, logic [31:0] d0,
                         bit r1, bit w1, logic [31:0] a1, logic [31:0] d1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int gcyc;
        for (int i = 0; i < 1024; i++) begin
            bmem[i] = 32'hA500_0000 | 32'(i);
            model_mem[i] = 32'hA500_0000 | 32'(i);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick;
        #1 chk("rst_req_gnt", p0_gnt, 0);
        chk("rst_req_mem_en", mem_en, 0);
        tick;
        rst = 1'b0;
        drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        #1 chk("t1_wr_gnt", p0_gnt, 1);
        chk("t1_wr_mem_we", mem_we, 1);
        chk("t1_wr_mem_addr", mem_addr, 4);
        tick;
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        #1 chk("t1_rd_mem_we", mem_we, 0);
        tick;
        idle;
        #1 chk("t1_rvalid", p0_rvalid, 1);
        chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
        tick;
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        #1 chk("t2_p0_gnt", p0_gnt, 1);
        chk("t2_p1_gnt", p1_gnt, 0);
        tick;
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
        #1 chk("t2_p1_gnt_next", p1_gnt, 1);
        chk("t2_p0_rvalid", p0_rvalid, 1);
        tick;
        idle;
        #1 chk("t2_p1_rvalid", p1_rvalid, 1);
        chk("t2_p1_rdata", p1_rdata, 32'hA500_0008);
        chk("t2_p0_quiet", p0_rvalid, 0);
        tick;
        gcyc = 0;
        for (int c = 1; c <= 8; c++) begin
            drive(1, 0, 32'(c * 4), 0, gcyc == 0, 1, 32'h40, 32'h1234_5678);
            #1;
            if (gcyc == 0 && p1_gnt) begin
                gcyc = c;
                chk("t3_p0_blocked", p0_gnt, 0);
            end
            tick;
        end
        chk("t3_grant_cycle", 32'(gcyc), 5);
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 32'h8, 0, 1, 0, 32'h40, 0);
            tick;
        end
        idle;
        tick;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(1, 0, 32'(i * 4), 0, 0, 0, 0, 0);
            else drive(0, 0, 0, 0, 1, 0, 32'h40, 0);
            tick;
        end
        idle;
        #1 chk("t4_last_p1_rdata", p1_rdata, 32'h1234_5678);
        tick;
        drive(0, 0, 0, 0, 1, 0, 32'h40, 0);
        tick;
        rst = 1'b1;
        idle;
        #1 chk("t5_rvalid_in_rst", p1_rvalid, 0);
        tick;
        tick;
        rst = 1'b0;
        #1 chk("t5_rvalid_after_rst", p1_rvalid, 0);
        tick;
        drive(1, 0, 32'h0000_1010, 0, 0, 0, 0, 0);
        #1 chk("wrap_mem_addr", mem_addr, 4);
        tick;
        idle;
        #1 chk("wrap_rdata", p0_rdata, 32'hDEADBEEF);
        tick;
        tick;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
